// File: rtl/frame_stream_source_if.sv
// Avalon-ST pixel stream carrying one video packet per frame.
// The master drives the pixel beats and the slave drives ready_in.
interface frame_stream_source_if #(
    parameter int DATA_WIDTH = 12
);
    logic                  valid_out;
    logic                  ready_in;
    logic                  startofpacket_out;
    logic                  endofpacket_out;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output valid_out,
        output startofpacket_out,
        output endofpacket_out,
        output data_out,
        input  ready_in
    );

    modport slave (
        input  valid_out,
        input  startofpacket_out,
        input  endofpacket_out,
        input  data_out,
        output ready_in
    );
endinterface

// File: rtl/frame_stream_source.sv
// Streams one raster-order frame out of a synchronous-read RAM as an Avalon-ST packet.
// Optional TEST_PATTERN_EN adds pattern_sel, which replaces RAM data with 8 vertical colour bars.
module frame_stream_source #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int DATA_WIDTH   = 12,
    parameter int ADDR_WIDTH   = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
`ifdef TEST_PATTERN_EN
    input  logic                  pattern_sel,
`endif
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_data,
    frame_stream_source_if.master st,
    output logic                  busy,
    output logic                  frame_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);
    localparam int ENTRY_W = DATA_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [1:0]              count_reg;
    logic                    wr_ptr_reg, rd_ptr_reg;
    logic                    rd_pending_reg, pend_sop_reg, pend_eop_reg;
    logic                    pop, push, issue, last_issue;
    logic [2:0]              occupancy;
    logic [DATA_WIDTH-1:0]   src_data;
    logic [ENTRY_W-1:0]      entry_q [2];
    logic [ENTRY_W-1:0]      head;

    // Entries already held plus the read in flight, minus the beat leaving this clk.
    assign pop        = st.valid_out && st.ready_in;
    assign push       = rd_pending_reg;
    assign occupancy  = {1'b0, count_reg} + {2'b00, rd_pending_reg} - {2'b00, pop};
    assign issue      = (state_reg == READ) && (occupancy < 3'd2);
    assign last_issue = issue && (addr_reg == LAST_ADDR);
    assign head       = entry_q[rd_ptr_reg];

    assign ram_addr             = addr_reg;
    assign st.valid_out         = (count_reg != 2'd0);
    assign st.data_out          = st.valid_out ? head[DATA_WIDTH-1:0] : '0;
    assign st.startofpacket_out = st.valid_out && head[ENTRY_W-1];
    assign st.endofpacket_out   = st.valid_out && head[ENTRY_W-2];
    assign busy                 = (state_reg != IDLE);
    assign frame_done           = (state_reg == DONE);

    // Each entry is {sop, eop, pixel}; the tags travel with the data they were issued with.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            logic [ENTRY_W-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == 1'(gi)))
                    entry_reg <= {pend_sop_reg, pend_eop_reg, src_data};
            end
            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg      <= 2'd0;
            wr_ptr_reg     <= 1'b0;
            rd_ptr_reg     <= 1'b0;
            rd_pending_reg <= 1'b0;
            pend_sop_reg   <= 1'b0;
            pend_eop_reg   <= 1'b0;
            addr_reg       <= '0;
        end else begin
            count_reg      <= count_reg + 2'(push) - 2'(pop);
            rd_pending_reg <= issue;
            pend_sop_reg   <= issue && (addr_reg == '0);
            pend_eop_reg   <= last_issue;
            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            if (state_reg == DONE)
                addr_reg <= '0;
            else if (issue && !last_issue)
                addr_reg <= addr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable) state_next = READ;
            READ:    if (last_issue) state_next = DRAIN;
            DRAIN:   if (pop && head[ENTRY_W-2]) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

`ifdef TEST_PATTERN_EN
    localparam int BAR_W = IMAGE_WIDTH / 8;
    localparam int BPW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic                  pattern_sel_reg;
    logic [BPW-1:0]        bar_pos_reg;
    logic [2:0]            bar_reg;
    logic [DATA_WIDTH-1:0] bar_colour, pattern_reg;

    always_comb begin
        bar_colour = '0;
        case (bar_reg)
            3'd0:    bar_colour = DATA_WIDTH'(12'hFFF);
            3'd1:    bar_colour = DATA_WIDTH'(12'hFF0);
            3'd2:    bar_colour = DATA_WIDTH'(12'h0FF);
            3'd3:    bar_colour = DATA_WIDTH'(12'h0F0);
            3'd4:    bar_colour = DATA_WIDTH'(12'hF0F);
            3'd5:    bar_colour = DATA_WIDTH'(12'hF00);
            3'd6:    bar_colour = DATA_WIDTH'(12'h00F);
            default: bar_colour = '0;
        endcase
    end

    // Bar index tracks the column of the issued read; 8 bars span exactly one line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_sel_reg <= 1'b0;
            bar_pos_reg     <= '0;
            bar_reg         <= 3'd0;
            pattern_reg     <= '0;
        end else begin
            if ((state_reg == IDLE) && enable)
                pattern_sel_reg <= pattern_sel;
            if (state_reg == DONE) begin
                bar_pos_reg <= '0;
                bar_reg     <= 3'd0;
            end else if (issue) begin
                if (bar_pos_reg == BPW'(BAR_W - 1)) begin
                    bar_pos_reg <= '0;
                    bar_reg     <= bar_reg + 3'd1;
                end else begin
                    bar_pos_reg <= bar_pos_reg + 1'b1;
                end
            end
            if (issue)
                pattern_reg <= bar_colour;
        end
    end

    assign ram_rd_en = issue && !pattern_sel_reg;
    assign src_data  = pattern_sel_reg ? pattern_reg : ram_data;
`else
    assign ram_rd_en = issue;
    assign src_data  = ram_data;
`endif

endmodule
